// File: rtl/instr_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: FSM states, fault codes
// and the PC alignment test.
package instr_fetch_unit_pkg;

  typedef enum logic [2:0] {
    FS_IDLE  = 3'd0,
    FS_REQ   = 3'd1,
    FS_HOLD  = 3'd2,
    FS_ADV   = 3'd3,
    FS_FAULT = 3'd4
  } fetch_state_e;

  typedef enum logic [1:0] {
    FC_NONE     = 2'b00,
    FC_MISALIGN = 2'b01,
    FC_TIMEOUT  = 2'b10
  } fault_code_e;

  // Instructions are word aligned, so only the two low PC bits matter.
  function automatic logic is_aligned(input logic [1:0] pc_low);
    return (pc_low == 2'b00);
  endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Memory read bus plus the decode-side valid/ready handshake.
// master = fetch unit side, slave = memory / decode side.
interface instr_fetch_unit_if #(
  parameter int DWIDTH = 32
) ();

  logic              mem_req;
  logic [DWIDTH-1:0] mem_addr;
  logic              mem_ack;
  logic [DWIDTH-1:0] mem_rdata;
  logic [DWIDTH-1:0] instr;
  logic [DWIDTH-1:0] instr_pc;
  logic              instr_valid;
  logic              instr_ready;

  modport master (
    output mem_req, mem_addr,
    input  mem_ack, mem_rdata,
    output instr, instr_pc, instr_valid,
    input  instr_ready
  );

  modport slave (
    input  mem_req, mem_addr,
    output mem_ack, mem_rdata,
    input  instr, instr_pc, instr_valid,
    output instr_ready
  );

endinterface

// File: rtl/instr_fetch_unit_wait_timer.sv
// Counts unacknowledged request cycles and flags the last allowed one.
// The counter saturates instead of wrapping so a stuck bus can never look
// like a fresh transaction.
module fetch_wait_timer #(
  parameter int MAX_WAIT = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic inc,
  output logic expired
);

  localparam int CW = $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] LAST = CW'(MAX_WAIT - 1);
  localparam logic [CW-1:0] SAT  = CW'(MAX_WAIT);

  logic [CW-1:0] count_q, count_d;

  // Next count: clear has priority, otherwise step up until saturation.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (inc && (count_q != SAT)) begin
      count_d = count_q + CW'(1);
    end
  end

  // Counter register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired = inc && (count_q == LAST);

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: reads memory at the current PC, hands the word to
// decode, then strobes pc_en once so the PC controller advances exactly once
// per accepted instruction. Misaligned PCs and bus timeouts are sticky faults.
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter int DWIDTH   = 32,
  parameter int MAX_WAIT = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fetch_en,
  input  logic [DWIDTH-1:0] pc_value,
  output logic              pc_en,
  output logic              fault,
  output logic [1:0]        fault_code,
  instr_fetch_unit_if.master bus
);

  fetch_state_e      state_q, state_d;
  logic [DWIDTH-1:0] instr_q, instr_d;
  logic [DWIDTH-1:0] instr_pc_q, instr_pc_d;
  logic              instr_valid_q, instr_valid_d;
  logic              pc_en_q, pc_en_d;
  logic              fault_q, fault_d;
  fault_code_e       fault_code_q, fault_code_d;

  logic in_req;
  logic pc_aligned;
  logic timer_clear;
  logic timer_inc;
  logic timer_expired;

  // The timer only runs while an aligned request waits for its ack.
  assign in_req      = (state_q == FS_REQ);
  assign pc_aligned  = is_aligned(pc_value[1:0]);
  assign timer_inc   = in_req && pc_aligned && !bus.mem_ack;
  assign timer_clear = !in_req || bus.mem_ack;

  fetch_wait_timer #(
    .MAX_WAIT (MAX_WAIT)
  ) u_wait_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (timer_clear),
    .inc     (timer_inc),
    .expired (timer_expired)
  );

  // Bus drive and next-state logic; the ack check comes before the timeout
  // so an ack on the last allowed cycle still completes the fetch.
  always_comb begin
    state_d       = state_q;
    instr_d       = instr_q;
    instr_pc_d    = instr_pc_q;
    instr_valid_d = instr_valid_q;
    pc_en_d       = pc_en_q;
    fault_d       = fault_q;
    fault_code_d  = fault_code_q;
    bus.mem_req   = 1'b0;
    bus.mem_addr  = '0;
    case (state_q)
      FS_IDLE: begin
        if (fetch_en) begin
          state_d = FS_REQ;
        end
      end
      FS_REQ: begin
        bus.mem_addr = pc_value;
        bus.mem_req  = pc_aligned;
        if (!pc_aligned) begin
          state_d      = FS_FAULT;
          fault_d      = 1'b1;
          fault_code_d = FC_MISALIGN;
        end else if (bus.mem_ack) begin
          state_d       = FS_HOLD;
          instr_d       = bus.mem_rdata;
          instr_pc_d    = pc_value;
          instr_valid_d = 1'b1;
        end else if (timer_expired) begin
          state_d      = FS_FAULT;
          fault_d      = 1'b1;
          fault_code_d = FC_TIMEOUT;
        end
      end
      FS_HOLD: begin
        if (bus.instr_ready) begin
          state_d       = FS_ADV;
          instr_valid_d = 1'b0;
          pc_en_d       = 1'b1;
        end
      end
      FS_ADV: begin
        pc_en_d = 1'b0;
        state_d = fetch_en ? FS_REQ : FS_IDLE;
      end
      FS_FAULT: begin
        state_d = FS_FAULT;
      end
      default: begin
        state_d = FS_IDLE;
      end
    endcase
  end

  // State and registered outputs, cleared by synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= FS_IDLE;
      instr_q       <= '0;
      instr_pc_q    <= '0;
      instr_valid_q <= 1'b0;
      pc_en_q       <= 1'b0;
      fault_q       <= 1'b0;
      fault_code_q  <= FC_NONE;
    end else begin
      state_q       <= state_d;
      instr_q       <= instr_d;
      instr_pc_q    <= instr_pc_d;
      instr_valid_q <= instr_valid_d;
      pc_en_q       <= pc_en_d;
      fault_q       <= fault_d;
      fault_code_q  <= fault_code_d;
    end
  end

  assign bus.instr       = instr_q;
  assign bus.instr_pc    = instr_pc_q;
  assign bus.instr_valid = instr_valid_q;
  assign pc_en           = pc_en_q;
  assign fault           = fault_q;
  assign fault_code      = fault_code_q;

endmodule
